// File: rtl/thrust_input_cond.sv
// Thrust/rotation input conditioner feeding the lander core: analog stick or D-pad ramp to thrust, hysteretic turn requests.
// Optional build macro THRUST_SLEW_EN: analog thrust slews by SLEW_STEP per ramp tick instead of following the stick directly.
//
// state | meaning
// IDLE  | no rotate request
// LEFT  | rotate-left engaged, held until x rises above -TURN_OFF
// RIGHT | rotate-right engaged, held until x falls below TURN_OFF
module thrust_input_cond #(
   parameter int TICK_DIV   = 98425,
   parameter int MAX_THRUST = 254,
   parameter int TURN_ON    = 64,
   parameter int TURN_OFF   = 48,
   parameter int SLEW_STEP  = 8
) (
   input  logic       clk_25,
   input  logic       reset,
   input  logic [7:0] analog_y,
   input  logic [7:0] analog_x,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       dpad_mode,
   output logic [7:0] thrust,
   output logic       turn_l,
   output logic       turn_r,
   output logic       tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]     CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [7:0]        THR_MAX  = 8'(MAX_THRUST);
   localparam logic signed [8:0] ON_P     = 9'(TURN_ON);
   localparam logic signed [8:0] ON_N     = 9'(-TURN_ON);
   localparam logic signed [8:0] OFF_P    = 9'(TURN_OFF);
   localparam logic signed [8:0] OFF_N    = 9'(-TURN_OFF);

   if (TURN_OFF >= TURN_ON) begin : g_bad_hyst
      $error("thrust_input_cond: TURN_OFF must be below TURN_ON");
   end
   if (SLEW_STEP < 1 || SLEW_STEP > MAX_THRUST) begin : g_bad_step
      $error("thrust_input_cond: SLEW_STEP out of range");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } turn_state_t;

   logic [CW-1:0]     presc;
   logic [7:0]        acc;
   logic signed [8:0] y9;
   logic signed [8:0] raw9;
   logic signed [8:0] x9;
   logic [7:0]        target;
   logic [7:0]        analog_next;
   turn_state_t       state;
   turn_state_t       state_next;

   // Ramp prescaler: tick fires the cycle after the count reaches its last value.
   always_ff @(posedge clk_25) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (presc == CNT_LAST);
         presc <= (presc == CNT_LAST) ? '0 : presc + CW'(1);
      end
   end

   assign y9     = {analog_y[7], analog_y};
   assign raw9   = 9'sd127 - y9;
   assign target = ($unsigned(raw9) > {1'b0, THR_MAX}) ? THR_MAX : raw9[7:0];

   always_ff @(posedge clk_25) begin
      if (reset) begin
         acc <= 8'd0;
      end else if (tick) begin
         if (btn_up && !btn_down && (acc < THR_MAX)) begin
            acc <= acc + 8'd1;
         end else if (btn_down && !btn_up && (acc != 8'd0)) begin
            acc <= acc - 8'd1;
         end
      end
   end

`ifdef THRUST_SLEW_EN
   localparam logic [7:0] STEP = 8'(SLEW_STEP);

   // Step toward target, landing exactly on it when the remaining gap is small.
   always_comb begin
      analog_next = thrust;
      if (tick) begin
         if (target > thrust) begin
            analog_next = ((target - thrust) > STEP) ? thrust + STEP : target;
         end else if (target < thrust) begin
            analog_next = ((thrust - target) > STEP) ? thrust - STEP : target;
         end
      end
   end
`else
   assign analog_next = target;
`endif

   always_ff @(posedge clk_25) begin
      if (reset) begin
         thrust <= 8'd0;
      end else begin
         thrust <= dpad_mode ? acc : analog_next;
      end
   end

   assign x9 = {analog_x[7], analog_x};

   always_ff @(posedge clk_25) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Strict compares keep exact-threshold inputs from switching; no LEFT<->RIGHT shortcut.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (x9 < ON_N) begin
               state_next = LEFT;
            end else if (x9 > ON_P) begin
               state_next = RIGHT;
            end
         end
         LEFT: begin
            if (x9 > OFF_N) begin
               state_next = IDLE;
            end
         end
         RIGHT: begin
            if (x9 < OFF_P) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_25) begin
      if (reset) begin
         turn_l <= 1'b0;
         turn_r <= 1'b0;
      end else begin
         turn_l <= (state_next == LEFT);
         turn_r <= (state_next == RIGHT);
      end
   end

endmodule

// File: tb/tb_thrust_input_cond.sv
// Self-checking bench for thrust_input_cond: vector table, hand sequences and randomized run against a behavioural model.
module tb_thrust_input_cond;
   localparam int TD   = 10;
   localparam int MAXT = 254;
   localparam int STEP = 8;

   logic       clk_25 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] analog_y = 8'd0;
   logic [7:0] analog_x = 8'd0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       dpad_mode = 1'b0;
   logic [7:0] thrust;
   logic       turn_l;
   logic       turn_r;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   int m_k = 0;
   int m_acc = 0;
   int m_thr = 0;
   int m_dir = 0;
   bit m_tick = 1'b0;

   always #5 clk_25 = ~clk_25;

   thrust_input_cond #(.TICK_DIV(TD)) dut (
      .clk_25   (clk_25),
      .reset    (reset),
      .analog_y (analog_y),
      .analog_x (analog_x),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .dpad_mode(dpad_mode),
      .thrust   (thrust),
      .turn_l   (turn_l),
      .turn_r   (turn_r),
      .tick     (tick)
   );

   always @(posedge clk_25) begin : model
      int  xs;
      int  tgt;
      bit  t_old;
      if (reset) begin
         m_k = 0; m_tick = 0; m_acc = 0; m_thr = 0; m_dir = 0;
      end else begin
         t_old = m_tick;
         tgt = 127 - int'($signed(analog_y));
         if (tgt > MAXT) tgt = MAXT;
         xs = int'($signed(analog_x));
         if (dpad_mode) begin
            m_thr = m_acc;
         end else begin
`ifdef THRUST_SLEW_EN
            if (t_old) begin
               if (tgt > m_thr) m_thr = (tgt - m_thr > STEP) ? m_thr + STEP : tgt;
               else if (tgt < m_thr) m_thr = (m_thr - tgt > STEP) ? m_thr - STEP : tgt;
            end
`else
            m_thr = tgt;
`endif
         end
         if (t_old) begin
            if (btn_up && !btn_down && m_acc < MAXT) m_acc = m_acc + 1;
            else if (btn_down && !btn_up && m_acc > 0) m_acc = m_acc - 1;
         end
         if (m_dir == 0) begin
            if (xs < -64) m_dir = -1;
            else if (xs > 64) m_dir = 1;
         end else if (m_dir < 0) begin
            if (xs > -48) m_dir = 0;
         end else begin
            if (xs < 48) m_dir = 0;
         end
         m_k = m_k + 1;
         m_tick = (m_k % TD) == 0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk_25);
      check("model_thrust", int'(thrust), m_thr);
      check("model_turn_l", int'(turn_l), (m_dir < 0) ? 1 : 0);
      check("model_turn_r", int'(turn_r), (m_dir > 0) ? 1 : 0);
      check("model_tick",   int'(tick),   m_tick ? 1 : 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   typedef struct {
      int y;
      int x;
      int thr;
      bit l;
      bit r;
   } vec_t;

   vec_t tv[20];

   initial begin
      int last;
      tv = '{
         '{-128,    0, 254, 1'b0, 1'b0},
         '{ 127,    0,   0, 1'b0, 1'b0},
         '{   0,    0, 127, 1'b0, 1'b0},
         '{-127,    0, 254, 1'b0, 1'b0},
         '{-126,    0, 253, 1'b0, 1'b0},
         '{ 126,    0,   1, 1'b0, 1'b0},
         '{   0,    0, 127, 1'b0, 1'b0},
         '{   0,  -65, 127, 1'b1, 1'b0},
         '{   0,  -49, 127, 1'b1, 1'b0},
         '{   0,  -47, 127, 1'b0, 1'b0},
         '{   0,    0, 127, 1'b0, 1'b0},
         '{   0,   64, 127, 1'b0, 1'b0},
         '{   0,   65, 127, 1'b0, 1'b1},
         '{   0,   48, 127, 1'b0, 1'b1},
         '{   0,   47, 127, 1'b0, 1'b0},
         '{   0,  -64, 127, 1'b0, 1'b0},
         '{   0, -128, 127, 1'b1, 1'b0},
         '{   0,  127, 127, 1'b0, 1'b0},
         '{   0,  127, 127, 1'b0, 1'b1},
         '{   0,  -48, 127, 1'b0, 1'b0}
      };

      // reset state
      @(negedge clk_25);
      @(negedge clk_25);
      check("rst_thrust", int'(thrust), 0);
      check("rst_turn_l", int'(turn_l), 0);
      check("rst_turn_r", int'(turn_r), 0);
      check("rst_tick",   int'(tick),   0);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         analog_y = 8'(tv[i].y);
         analog_x = 8'(tv[i].x);
         cyc();
`ifndef THRUST_SLEW_EN
         check($sformatf("vec%0d_thrust", i), int'(thrust), tv[i].thr);
`endif
         check($sformatf("vec%0d_turn_l", i), int'(turn_l), int'(tv[i].l));
         check($sformatf("vec%0d_turn_r", i), int'(turn_r), int'(tv[i].r));
      end

      // D-pad ramp to the ceiling and back down
      analog_x = 8'd0;
      dpad_mode = 1'b1;
      btn_up = 1'b1;
      run(300 * TD);
      btn_up = 1'b0;
      run(2);
      check("ramp_ceiling", int'(thrust), 254);
      btn_down = 1'b1;
      run(10 * TD);
      btn_down = 1'b0;
      run(2);
      check("ramp_down10", int'(thrust), 244);
      btn_down = 1'b1;
      run(144 * TD);
      btn_down = 1'b0;
      run(2);
      check("ramp_to100", int'(thrust), 100);

      // both buttons hold; measure tick spacing
      btn_up = 1'b1;
      btn_down = 1'b1;
      last = -1;
      for (int i = 0; i < 20 * TD; i++) begin
         cyc();
         if (tick) begin
            if (last >= 0) check("tick_period", i - last, TD);
            last = i;
         end
      end
      btn_up = 1'b0;
      btn_down = 1'b0;
      run(2);
      check("both_hold", int'(thrust), 100);

      // reset mid-ramp with a turn engaged
      analog_x = 8'h80;
      btn_down = 1'b1;
      run(50 * TD);
      check("pre_rst_turn_l", int'(turn_l), 1);
      reset = 1'b1;
      cyc();
      check("midrst_thrust", int'(thrust), 0);
      check("midrst_turn_l", int'(turn_l), 0);
      check("midrst_tick",   int'(tick),   0);
      reset = 1'b0;
      btn_down = 1'b0;
      analog_x = 8'd0;
      run(3 * TD);
      check("post_rst_acc", int'(thrust), 0);

      // analog full-scale step from zero thrust
      dpad_mode = 1'b0;
      analog_y = 8'd127;
      run(2);
      check("step_start", int'(thrust), 0);
      analog_y = 8'h80;
      cyc();
`ifdef THRUST_SLEW_EN
      run(32 * TD + 1);
`endif
      check("step_full", int'(thrust), 254);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         if ((i % 3) == 0) analog_x = 8'($urandom_range(0, 255));
         if ((i % 7) == 0) analog_y = 8'($urandom_range(0, 255));
         if ((i % 23) == 0) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
         end
         if ((i % 97) == 0) dpad_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 499) == 0) reset = 1'b1;
         else reset = 1'b0;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
